// File: rtl/axi_mem_responder.sv
// AXI4 slave in front of a word array: one FIXED/INCR burst at a time, byte-strobe writes.
// Define AXI_MEM_RESPONDER_INIT_EN to clear the array on rst_ni; otherwise it has no reset.
package axi_mem_responder_pkg;
  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } ax_chan_t;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  strb;
    logic        last;
  } w_chan_t;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
    logic [0:0] user;
  } b_chan_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [0:0]  user;
  } r_chan_t;

  typedef struct packed {
    ax_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ax_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    b_chan_t b;
    logic    r_valid;
    r_chan_t r;
  } resp_t;
endpackage

// state | meaning
// IDLE  | arbitrate AW/AR after one settling cycle
// WRITE | accepting W beats
// WRESP | holding B until b_ready
// READ  | emitting R beats
module axi_mem_responder #(
  parameter int unsigned NumWords  = 1024,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned IdWidth   = 4,
  parameter type req_t  = axi_mem_responder_pkg::req_t,
  parameter type resp_t = axi_mem_responder_pkg::resp_t
) (
  input  logic  clk_i,
  input  logic  rst_ni,
  input  req_t  slv_req_i,
  output resp_t slv_resp_o
);

  localparam int unsigned StrbW = DataWidth / 8;
  localparam int unsigned OffW  = $clog2(StrbW);
  localparam int unsigned IdxW  = $clog2(NumWords);
  localparam logic [2:0] MaxSize    = 3'(OffW);
  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;
  localparam logic [1:0] RespDecErr = 2'b11;
  localparam logic [1:0] BurstFixed = 2'b00;
  localparam logic [1:0] BurstWrap  = 2'b10;

  typedef enum logic [1:0] {IDLE, WRITE, WRESP, READ} state_e;

  state_e               state_q, state_d;
  logic [IdWidth-1:0]   id_q, id_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic [7:0]           len_q, len_d;
  logic [2:0]           size_q, size_d;
  logic [1:0]           burst_q, burst_d;
  logic [7:0]           cnt_q, cnt_d;
  logic [1:0]           err_q, err_d;
  logic                 last_read_q, last_read_d;
  logic                 ready_en_q, ready_en_d;

  logic [DataWidth-1:0] mem [NumWords];

  logic [AddrWidth-1:0] word_addr, addr_next;
  logic [IdxW-1:0]      idx;
  logic [1:0]           beat_code;
  logic                 last_beat;
  logic                 mem_we;
  logic [DataWidth-1:0] wdata, rdata;
  logic [StrbW-1:0]     wstrb;
  logic                 aw_ready, ar_ready, w_ready, b_valid, r_valid;
  logic                 grant_w, grant_r;

  function automatic logic [1:0] worse(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

  assign word_addr = addr_q >> OffW;
  assign idx       = word_addr[IdxW-1:0];
  assign addr_next = (burst_q == BurstFixed) ? addr_q : addr_q + (AddrWidth'(1) << size_q);
  assign last_beat = (cnt_q == len_q);
  assign wdata     = slv_req_i.w.data;
  assign wstrb     = slv_req_i.w.strb;
  assign rdata     = mem[idx];

  // A malformed burst never touches memory, so it outranks the range check.
  always_comb begin
    beat_code = RespOkay;
    if (burst_q == BurstWrap || size_q > MaxSize) begin
      beat_code = RespSlvErr;
    end else if (word_addr >= AddrWidth'(NumWords)) begin
      beat_code = RespDecErr;
    end
  end

  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    addr_d      = addr_q;
    len_d       = len_q;
    size_d      = size_q;
    burst_d     = burst_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    last_read_d = last_read_q;
    aw_ready    = 1'b0;
    ar_ready    = 1'b0;
    w_ready     = 1'b0;
    b_valid     = 1'b0;
    r_valid     = 1'b0;
    mem_we      = 1'b0;
    grant_w     = 1'b0;
    grant_r     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ready_en_q) begin
          // Round-robin only matters on a conflict; single requests don't move the flag.
          grant_w = slv_req_i.aw_valid && (!slv_req_i.ar_valid || last_read_q);
          grant_r = slv_req_i.ar_valid && !grant_w;
          if (slv_req_i.aw_valid && slv_req_i.ar_valid) last_read_d = grant_r;
        end
        aw_ready = grant_w;
        ar_ready = grant_r;
        if (grant_w || grant_r) begin
          id_d    = grant_w ? slv_req_i.aw.id    : slv_req_i.ar.id;
          addr_d  = grant_w ? slv_req_i.aw.addr  : slv_req_i.ar.addr;
          len_d   = grant_w ? slv_req_i.aw.len   : slv_req_i.ar.len;
          size_d  = grant_w ? slv_req_i.aw.size  : slv_req_i.ar.size;
          burst_d = grant_w ? slv_req_i.aw.burst : slv_req_i.ar.burst;
          cnt_d   = '0;
          err_d   = RespOkay;
          state_d = grant_w ? WRITE : READ;
        end
      end
      WRITE: begin
        w_ready = 1'b1;
        if (slv_req_i.w_valid) begin
          mem_we = (beat_code == RespOkay);
          err_d  = worse(worse(err_q, beat_code),
                         (slv_req_i.w.last != last_beat) ? RespSlvErr : RespOkay);
          addr_d = addr_next;
          cnt_d  = cnt_q + 8'd1;
          if (last_beat) state_d = WRESP;
        end
      end
      WRESP: begin
        b_valid = 1'b1;
        if (slv_req_i.b_ready) state_d = IDLE;
      end
      READ: begin
        r_valid = 1'b1;
        if (slv_req_i.r_ready) begin
          addr_d = addr_next;
          cnt_d  = cnt_q + 8'd1;
          if (last_beat) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Address channels open only after a full cycle spent in IDLE.
  assign ready_en_d = (state_q == IDLE) && (state_d == IDLE);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      id_q        <= '0;
      addr_q      <= '0;
      len_q       <= '0;
      size_q      <= '0;
      burst_q     <= '0;
      cnt_q       <= '0;
      err_q       <= RespOkay;
      last_read_q <= 1'b0;
      ready_en_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      id_q        <= id_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      size_q      <= size_d;
      burst_q     <= burst_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      last_read_q <= last_read_d;
      ready_en_q  <= ready_en_d;
    end
  end

`ifdef AXI_MEM_RESPONDER_INIT_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(NumWords); i++) mem[i] <= '0;
    end else if (mem_we) begin
      for (int b = 0; b < int'(StrbW); b++) begin
        if (wstrb[b]) mem[idx][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end
`else
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int b = 0; b < int'(StrbW); b++) begin
        if (wstrb[b]) mem[idx][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end
`endif

  always_comb begin
    slv_resp_o          = '0;
    slv_resp_o.aw_ready = aw_ready;
    slv_resp_o.ar_ready = ar_ready;
    slv_resp_o.w_ready  = w_ready;
    slv_resp_o.b_valid  = b_valid;
    slv_resp_o.r_valid  = r_valid;
    if (b_valid) begin
      slv_resp_o.b.id   = id_q;
      slv_resp_o.b.resp = err_q;
    end
    if (r_valid) begin
      slv_resp_o.r.id   = id_q;
      slv_resp_o.r.data = (beat_code == RespOkay) ? rdata : '0;
      slv_resp_o.r.resp = beat_code;
      slv_resp_o.r.last = last_beat;
    end
  end

endmodule
